// File: rtl/sbus_mem_bank.sv
// SBUS phase bank: first slot LATENCY cycles after START, then one slot/cycle; START ignored while BUSY (no queueing).
// Optional SBUS_MEM_ACK_AHEAD_EN: read ACKN leads VALID by one cycle.
module sbus_mem_bank #(
  parameter int WIDTH   = 36,
  parameter int DEPTH   = 32768,
  parameter int WORDS   = 4,
  parameter int ADDR_W  = 22,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              CROBAR_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [WORDS-1:0]  RQ,
  input  logic              WR,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              DIN_PAR,
  output logic              ACKN,
  output logic              VALID,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DOUT_PAR,
  output logic              PAR_ERR,
  output logic              BUSY
);
  localparam int LW = $clog2(WORDS);
  localparam int LD = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 2);

  typedef logic [LW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [LD-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ACCESS, XFER, WTAIL} state_t;

  state_t            state, state_n;
  cnt_t              cnt, cnt_n;
  ptr_t              ptr, ptr_n, last, offs;
  logic [ADDR_W-1:0] adr_q;
  logic [WORDS-1:0]  rq_q;
  logic              wr_q;
  logic              accept, slot_go, ackn_n, valid_n;
  idx_t              idx_n, cur_idx;
  logic              adr_unused;
  logic [WIDTH-1:0]  mem [DEPTH];

  function automatic ptr_t top_bit(input logic [WORDS-1:0] m);
    ptr_t r;
    r = '0;
    for (int k = 0; k < WORDS; k++)
      if (m[k]) r = ptr_t'(k);
    return r;
  endfunction

  assign accept = (state == IDLE) && START && (RQ != '0);

  // Offset wraps inside the block; the block part of the address never advances.
  assign offs       = adr_q[LW-1:0] + ptr_n;
  assign idx_n      = {adr_q[LD-1:LW], offs};
  assign adr_unused = ^adr_q[ADDR_W-1:LD];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    slot_go = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = ACCESS;
          cnt_n   = cnt_t'(LATENCY);
        end
      end
      ACCESS: begin
        if (cnt == cnt_t'(1)) begin
          state_n = XFER;
          ptr_n   = '0;
          slot_go = 1'b1;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      XFER: begin
        if (ptr == last) begin
          state_n = wr_q ? WTAIL : IDLE;
        end else begin
          ptr_n   = ptr + ptr_t'(1);
          slot_go = 1'b1;
        end
      end
      WTAIL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef SBUS_MEM_ACK_AHEAD_EN
  ptr_t ptr_nx;
  assign ptr_nx = ptr_n + ptr_t'(1);
`endif

  // Slot outputs are registered on the edge that enters the slot.
  always_comb begin
    valid_n = slot_go && rq_q[ptr_n] && !wr_q;
    ackn_n  = slot_go && rq_q[ptr_n];
`ifdef SBUS_MEM_ACK_AHEAD_EN
    if (state == IDLE) begin
      ackn_n = (LATENCY == 1) && accept && !WR && RQ[0];
    end else if (!wr_q) begin
      if (slot_go)
        ackn_n = (ptr_n != last) && rq_q[ptr_nx];
      else
        ackn_n = (state == ACCESS) && (cnt == cnt_t'(2)) && rq_q[0];
    end
`endif
  end

  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      last     <= '0;
      adr_q    <= '0;
      rq_q     <= '0;
      wr_q     <= 1'b0;
      cur_idx  <= '0;
      ACKN     <= 1'b0;
      VALID    <= 1'b0;
      DOUT     <= '0;
      DOUT_PAR <= 1'b0;
      PAR_ERR  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      BUSY     <= (state_n != IDLE);
      ACKN     <= ackn_n;
      VALID    <= valid_n;
      DOUT     <= valid_n ? mem[idx_n] : '0;
      DOUT_PAR <= valid_n ? ^mem[idx_n] : 1'b0;
      if (slot_go)
        cur_idx <= idx_n;
      if (accept) begin
        adr_q   <= ADR;
        rq_q    <= RQ;
        wr_q    <= WR;
        last    <= top_bit(RQ);
        PAR_ERR <= 1'b0;
      end else if (ACKN && wr_q && ((^DIN) != DIN_PAR)) begin
        PAR_ERR <= 1'b1;
      end
    end
  end

  // Write data arrives in the cycle of its ACKN; a reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (CROBAR_N && ACKN && wr_q)
      mem[cur_idx] <= DIN;
  end
endmodule

// File: tb/tb_sbus_mem_bank.sv
// Randomized bench for sbus_mem_bank against a slot-timeline reference model.
module tb_sbus_mem_bank;
  localparam int WIDTH  = 36;
  localparam int DEPTH  = 32768;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 22;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              crobar_n;
  logic              start;
  logic [ADDR_W-1:0] adr;
  logic [WORDS-1:0]  rq;
  logic              wr;
  logic [WIDTH-1:0]  din;
  logic              din_par;
  logic              ackn, valid, dout_par, par_err, busy;
  logic [WIDTH-1:0]  dout;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   ahead;
  logic exp_perr;
  logic [WIDTH-1:0] mmem [DEPTH];

  sbus_mem_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WORDS(WORDS), .ADDR_W(ADDR_W), .LATENCY(LAT)
  ) dut (
    .clk(clk), .CROBAR_N(crobar_n), .START(start), .ADR(adr), .RQ(rq), .WR(wr),
    .DIN(din), .DIN_PAR(din_par), .ACKN(ackn), .VALID(valid), .DOUT(dout),
    .DOUT_PAR(dout_par), .PAR_ERR(par_err), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int widx(input logic [ADDR_W-1:0] a, input int s);
    int base, off;
    base = int'(a) - (int'(a) % WORDS);
    off  = ((int'(a) % WORDS) + s) % WORDS;
    return (base + off) % DEPTH;
  endfunction

  function automatic int hib(input logic [WORDS-1:0] m);
    int r;
    r = 0;
    for (int k = 0; k < WORDS; k++)
      if (m[k]) r = k;
    return r;
  endfunction

  function automatic bit slot(input logic [WORDS-1:0] m, input int last, input int s);
    if (s < 0 || s > last) return 1'b0;
    return m[s];
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_adr(input int off);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[14:0] = 15'(off);
    return a;
  endfunction

  task automatic do_reset();
    start = 1'b0;
    #1 crobar_n = 1'b0;
    #1;
    chk("rst ackn", ackn, 0);
    chk("rst valid", valid, 0);
    chk("rst dout", dout, 0);
    chk("rst dout_par", dout_par, 0);
    chk("rst busy", busy, 0);
    chk("rst par_err", par_err, 0);
    exp_perr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    crobar_n = 1'b1;
    #1 chk("post-rst busy", busy, 0);
  endtask

  // One accepted cycle; caller is mid-cycle with the bank idle.
  task automatic txn(input logic [ADDR_W-1:0] a, input logic [WORDS-1:0] m, input logic w,
                     input logic [WORDS-1:0] bad, input bit pat, input int rst_j);
    int last, jend, s;
    logic e_ackn, e_valid, e_busy;
    logic [WIDTH-1:0] e_dout, d, base;
    base = 36'h111111111;
    last = hib(m);
    jend = LAT + last + (w ? 1 : 0);
    start = 1'b1; adr = a; rq = m; wr = w;
    exp_perr = 1'b0;
    for (int j = 0; j <= jend + 1; j++) begin
      @(negedge clk);
      s       = j - LAT;
      e_valid = !w && slot(m, last, s);
      e_ackn  = w ? slot(m, last, s) : (ahead ? slot(m, last, s + 1) : e_valid);
      e_busy  = (j <= jend);
      e_dout  = e_valid ? mmem[widx(a, s)] : '0;
      chk($sformatf("ackn j%0d", j), ackn, e_ackn);
      chk($sformatf("valid j%0d", j), valid, e_valid);
      chk($sformatf("dout j%0d", j), dout, e_dout);
      chk($sformatf("dout_par j%0d", j), dout_par, ^e_dout);
      chk($sformatf("busy j%0d", j), busy, e_busy);
      chk($sformatf("par_err j%0d", j), par_err, exp_perr);
      if (j == rst_j) begin
        do_reset();
        return;
      end
      d = pat ? base * WIDTH'(s + 1) : WIDTH'({$urandom(), $urandom()});
      din = d;
      din_par = ^d;
      if (w && slot(m, last, s)) begin
        din_par = (^d) ^ bad[s];
        mmem[widx(a, s)] = d;
        if (bad[s]) exp_perr = 1'b1;
      end
      if (e_busy) begin
        start = ($urandom_range(0, 3) == 0);
        adr = ADDR_W'($urandom); rq = WORDS'($urandom); wr = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic rq0();
    start = 1'b1; rq = '0; adr = ADDR_W'($urandom); wr = 1'($urandom);
    @(negedge clk);
    chk("rq0 busy", busy, 0);
    chk("rq0 valid", valid, 0);
    chk("rq0 ackn", ackn, 0);
    chk("rq0 par_err", par_err, exp_perr);
    start = 1'b0;
    @(negedge clk);
    chk("rq0 busy2", busy, 0);
  endtask

  initial begin
`ifdef SBUS_MEM_ACK_AHEAD_EN
    ahead = 1'b1;
`else
    ahead = 1'b0;
`endif
    crobar_n = 1'b0; start = 1'b0; adr = '0; rq = '0; wr = 1'b0; din = '0; din_par = 1'b0;
    exp_perr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init ackn", ackn, 0);
    chk("init valid", valid, 0);
    chk("init dout", dout, 0);
    chk("init dout_par", dout_par, 0);
    chk("init busy", busy, 0);
    chk("init par_err", par_err, 0);
    crobar_n = 1'b1;
    @(negedge clk);

    for (int b = 0; b < 16; b++)
      txn(rnd_adr(16'h100 + 4 * b), 4'hF, 1'b1, 4'h0, 1'b0, -1);

    txn(rnd_adr(16'h100), 4'hF, 1'b1, 4'h0, 1'b1, -1);
    txn(rnd_adr(16'h100), 4'hF, 1'b0, 4'h0, 1'b0, -1);
    chk("pattern word 2", mmem[16'h102], 36'h333333333);
    txn(rnd_adr(16'h103), 4'b0011, 1'b0, 4'h0, 1'b0, -1);
    txn(rnd_adr(16'h100), 4'b0101, 1'b0, 4'h0, 1'b0, -1);
    rq0();
    txn(rnd_adr(16'h104), 4'hF, 1'b1, 4'b0010, 1'b0, -1);
    rq0();
    txn(rnd_adr(16'h104), 4'hF, 1'b0, 4'h0, 1'b0, -1);
    txn(rnd_adr(16'h108), 4'hF, 1'b0, 4'h0, 1'b0, LAT + 1);
    txn(rnd_adr(16'h108), 4'hF, 1'b0, 4'h0, 1'b0, -1);
    txn(rnd_adr(16'h10C), 4'hF, 1'b1, 4'h0, 1'b0, LAT + 1);
    txn(rnd_adr(16'h10C), 4'hF, 1'b0, 4'h0, 1'b0, -1);

    for (int i = 0; i < 200; i++) begin
      logic [WORDS-1:0] m, bad;
      m   = WORDS'($urandom_range(1, 15));
      bad = ($urandom_range(0, 3) == 0) ? WORDS'($urandom) : '0;
      if ($urandom_range(0, 9) == 0) rq0();
      txn(rnd_adr(16'h100 + $urandom_range(0, 63)), m, 1'($urandom), bad, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
